alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be a multiple of 4, range 8..32.
REQ-002 Parameter SHW, default 3, width of the shift count; SHALL equal clog2(WIDTH).
REQ-003 PHI2  in  1  sole clock; all state updates on the rising edge.
REQ-004 RES  in  1  synchronous, active-high reset.
REQ-005 START  in  1  operation request, sampled only while BUSY=0 or DONE=1.
REQ-006 OP  in  3  operation: 000 AND, 001 EOR, 010 OR, 011 SRS, 100 SUM, 101 DSUB, 110 SHRN, 111 reserved.
REQ-007 AI, BI  in  WIDTH each  operands, latched on accept.
REQ-008 CI  in  1  carry-in / shift-in bit, latched on accept.
REQ-009 DEC  in  1  decimal mode for SUM/DSUB, latched on accept.
REQ-010 SHCNT  in  SHW  shift count for SHRN, latched on accept.
REQ-011 ACLD  in  1  load accumulator on completion, latched on accept.
REQ-012 BUSY  out  1  operation in progress.
REQ-013 DONE  out  1  one-cycle completion pulse.
REQ-014 RESULT  out  WIDTH  registered result.
REQ-015 AC  out  WIDTH  accumulator register.
REQ-016 ACR, AVR, ZR  out  1 each  carry, signed overflow, zero flags, registered with RESULT.

Function
REQ-017 FSM states IDLE, EXEC, ADJ, SHF; DONE is a registered flag, not a state.
REQ-018 Accept: START=1 with state IDLE on an edge -> operands latched, state EXEC, BUSY=1 from the next cycle.
REQ-019 EXEC computes on one edge; AND/EOR/OR/SRS/binary SUM/DSUB/reserved then go to IDLE with DONE=1 for exactly one cycle (latency 2 edges from accept).
REQ-020 SUM = AI+BI+CI; DSUB = AI+~BI+CI (CI=1 means no borrow); ACR = carry out of MSB; AVR = two's-complement overflow.
REQ-021 SUM/DSUB with DEC=1: EXEC stores binary sum and per-nibble half carries, ADJ applies BCD correction LSB nibble first (add: +6 where nibble >9 or nibble carry, propagating; subtract: -6 where nibble borrow), then DONE; latency 3 edges; ACR = decimal carry (add) / not-borrow (subtract); AVR from binary stage.
REQ-022 SRS: RESULT = {CI, AI[WIDTH-1:1]}, ACR = AI[0], AVR=0.
REQ-023 SHRN: EXEC loads AI into shifter; SHF performs one right shift per edge, CI into MSB, ACR = last bit shifted out; SHCNT=n>0 -> n SHF edges then DONE (latency n+2); n=0 -> RESULT=AI, ACR=0, DONE after EXEC.
REQ-024 AND/EOR/OR: bitwise, ACR=AVR=0; reserved OP: RESULT=0, ACR=AVR=0, ZR=1.
REQ-025 ZR = (RESULT==0), updated only on completion.
REQ-026 On completion with latched ACLD=1, AC <= RESULT on the same edge; otherwise AC unchanged.
REQ-027 RESULT/flags hold their value until the next completion.
REQ-028 BUSY=1 in EXEC/ADJ/SHF; 0 in IDLE.
REQ-029 START while BUSY=1 and DONE=0 is ignored, no queueing; input changes mid-operation have no effect.
REQ-030 START in the DONE cycle is accepted (back-to-back), giving DONE of the new op no earlier than 2 edges later.

Reset
REQ-031 RES=1 on an edge -> state IDLE, BUSY=0, DONE=0, RESULT=0, AC=0, ACR=AVR=0, ZR=0; RES dominates START.
REQ-032 RES mid-operation aborts it; no DONE pulse, AC not loaded.

Verification (WIDTH=8 unless stated)
REQ-033 AND AI=F0 BI=3C -> RESULT=30, ACR=AVR=0, ZR=0, DONE 2 edges after accept.
REQ-034 SUM AI=7F BI=01 CI=0 DEC=0 ACLD=1 -> RESULT=80, AVR=1, ACR=0, AC=80.
REQ-035 SUM DEC=1 AI=58 BI=46 CI=1 -> RESULT=05, ACR=1, DONE 3 edges after accept; DSUB DEC=1 AI=12 BI=21 CI=1 -> RESULT=91, ACR=0.
REQ-036 SHRN AI=85 CI=1 SHCNT=3 -> RESULT=F0, ACR=1, DONE 5 edges after accept; START pulsed while BUSY ignored.
REQ-037 RES during second SHF edge -> next cycle BUSY=0, RESULT=0, AC=0, no DONE.
REQ-038 WIDTH=16 SUM DEC=1 AI=9999 BI=0001 CI=0 -> RESULT=0000, ACR=1, ZR=1.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle ALU with BCD adjust, serial right shifter, accumulator
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             PHI2,
  input  logic             RES,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             DEC,
  input  logic [SHW-1:0]   SHCNT,
  input  logic             ACLD,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] AC,
  output logic             ACR,
  output logic             AVR,
  output logic             ZR
);

  localparam int NNIB = WIDTH / 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_EOR  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_SRS  = 3'b011;
  localparam logic [2:0] OP_SUM  = 3'b100;
  localparam logic [2:0] OP_DSUB = 3'b101;
  localparam logic [2:0] OP_SHRN = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ADJ  = 2'd2,
    S_SHF  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ci_q, ci_d, dec_q, dec_d, acld_q, acld_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // sum_q holds the binary sum during ADJ and the shift register during SHF
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [NNIB-1:0]  hc_q, hc_d;
  logic             cy_q, cy_d, ov_q, ov_d;
  logic [WIDTH-1:0] result_q, result_d, ac_q, ac_d;
  logic             acr_q, acr_d, avr_q, avr_d, zr_q, zr_d, done_q, done_d;

  logic [WIDTH-1:0] b_eff, bin_sum, adj, res_c, shv;
  logic [NNIB-1:0]  bin_hc;
  logic             bin_cy, bin_ov, nc, dc, dca, cmpl, acr_c, avr_c;
  logic [4:0]       nsum, v;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    dec_d    = dec_q;
    acld_d   = acld_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    hc_d     = hc_q;
    cy_d     = cy_q;
    ov_d     = ov_q;
    result_d = result_q;
    ac_d     = ac_q;
    acr_d    = acr_q;
    avr_d    = avr_q;
    zr_d     = zr_q;
    done_d   = 1'b0;
    cmpl     = 1'b0;
    res_c    = '0;
    acr_c    = 1'b0;
    avr_c    = 1'b0;
    adj      = '0;
    dc       = 1'b0;
    dca      = 1'b0;
    v        = '0;
    nc       = ci_q;
    nsum     = '0;
    bin_hc   = '0;
    shv      = {ci_q, sum_q[WIDTH-1:1]};

    b_eff = (op_q == OP_DSUB) ? ~b_q : b_q;
    {bin_cy, bin_sum} = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ci_q};
    bin_ov = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (bin_sum[WIDTH-1] != a_q[WIDTH-1]);
    for (int k = 0; k < NNIB; k++) begin
      nsum      = {1'b0, a_q[4*k +: 4]} + {1'b0, b_eff[4*k +: 4]} + {4'b0000, nc};
      nc        = nsum[4];
      bin_hc[k] = nsum[4];
    end

    // Only the carry created by a +6 correction propagates; binary carries
    // are already folded into the stored sum.
    for (int k = 0; k < NNIB; k++) begin
      if (op_q == OP_SUM) begin
        v = {1'b0, sum_q[4*k +: 4]} + {4'b0000, dc};
        if (hc_q[k] || (v > 5'd9)) v = v + 5'd6;
        adj[4*k +: 4] = v[3:0];
        dc  = v[4];
        dca = hc_q[k] | v[4];
      end else begin
        adj[4*k +: 4] = hc_q[k] ? sum_q[4*k +: 4] : (sum_q[4*k +: 4] - 4'd6);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = OP;
          a_d     = AI;
          b_d     = BI;
          ci_d    = CI;
          dec_d   = DEC;
          cnt_d   = SHCNT;
          acld_d  = ACLD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_AND: begin cmpl = 1'b1; res_c = a_q & b_q; end
          OP_EOR: begin cmpl = 1'b1; res_c = a_q ^ b_q; end
          OP_OR:  begin cmpl = 1'b1; res_c = a_q | b_q; end
          OP_SRS: begin
            cmpl  = 1'b1;
            res_c = {ci_q, a_q[WIDTH-1:1]};
            acr_c = a_q[0];
          end
          OP_SUM, OP_DSUB: begin
            if (dec_q) begin
              sum_d   = bin_sum;
              hc_d    = bin_hc;
              cy_d    = bin_cy;
              ov_d    = bin_ov;
              state_d = S_ADJ;
            end else begin
              cmpl  = 1'b1;
              res_c = bin_sum;
              acr_c = bin_cy;
              avr_c = bin_ov;
            end
          end
          OP_SHRN: begin
            if (cnt_q == '0) begin
              cmpl  = 1'b1;
              res_c = a_q;
            end else begin
              sum_d   = a_q;
              state_d = S_SHF;
            end
          end
          default: cmpl = 1'b1;
        endcase
      end
      S_ADJ: begin
        cmpl  = 1'b1;
        res_c = adj;
        acr_c = (op_q == OP_SUM) ? dca : cy_q;
        avr_c = ov_q;
      end
      S_SHF: begin
        sum_d = shv;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          cmpl  = 1'b1;
          res_c = shv;
          acr_c = sum_q[0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmpl) begin
      result_d = res_c;
      acr_d    = acr_c;
      avr_d    = avr_c;
      zr_d     = (res_c == '0);
      done_d   = 1'b1;
      state_d  = S_IDLE;
      if (acld_q) ac_d = res_c;
    end
  end

  always_ff @(posedge PHI2) begin
    if (RES) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      dec_q    <= 1'b0;
      acld_q   <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      hc_q     <= '0;
      cy_q     <= 1'b0;
      ov_q     <= 1'b0;
      result_q <= '0;
      ac_q     <= '0;
      acr_q    <= 1'b0;
      avr_q    <= 1'b0;
      zr_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      dec_q    <= dec_d;
      acld_q   <= acld_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      hc_q     <= hc_d;
      cy_q     <= cy_d;
      ov_q     <= ov_d;
      result_q <= result_d;
      ac_q     <= ac_d;
      acr_q    <= acr_d;
      avr_q    <= avr_d;
      zr_q     <= zr_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign AC     = ac_q;
  assign ACR    = acr_q;
  assign AVR    = avr_q;
  assign ZR     = zr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (WIDTH 8 and 16)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, ci8 = 1'b0, dec8 = 1'b0, acld8 = 1'b0;
  logic [2:0]  op8 = 3'b000, sh8 = 3'b000;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, acr8, avr8, zr8;
  logic [7:0]  res8, ac8;

  logic        start16 = 1'b0, ci16 = 1'b0, dec16 = 1'b0, acld16 = 1'b0;
  logic [2:0]  op16 = 3'b000;
  logic [3:0]  sh16 = 4'h0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, acr16, avr16, zr16;
  logic [15:0] res16, ac16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .SHW(3)) u_dut8 (
    .PHI2(clk), .RES(rst), .START(start8), .OP(op8), .AI(a8), .BI(b8),
    .CI(ci8), .DEC(dec8), .SHCNT(sh8), .ACLD(acld8), .BUSY(busy8),
    .DONE(done8), .RESULT(res8), .AC(ac8), .ACR(acr8), .AVR(avr8), .ZR(zr8)
  );

  alu_seq #(.WIDTH(16), .SHW(4)) u_dut16 (
    .PHI2(clk), .RES(rst), .START(start16), .OP(op16), .AI(a16), .BI(b16),
    .CI(ci16), .DEC(dec16), .SHCNT(sh16), .ACLD(acld16), .BUSY(busy16),
    .DONE(done16), .RESULT(res16), .AC(ac16), .ACR(acr16), .AVR(avr16), .ZR(zr16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation and clocks the accept edge
  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic dec, input logic [2:0] sh, input logic acld);
    op8 = op; a8 = a; b8 = b; ci8 = ci; dec8 = dec; sh8 = sh; acld8 = acld;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("busy_after_accept", {31'd0, busy8}, 32'd1);
  endtask

  // n0 = edges already elapsed since (and including) the accept edge
  task automatic wait8(input int n0, input int exp_lat, input string tag);
    int n;
    n = n0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic flags8(input string tag, input logic [7:0] r, input logic c,
                        input logic v, input logic z);
    chk({tag, "_result"}, {24'd0, res8}, {24'd0, r});
    chk({tag, "_acr"}, {31'd0, acr8}, {31'd0, c});
    chk({tag, "_avr"}, {31'd0, avr8}, {31'd0, v});
    chk({tag, "_zr"}, {31'd0, zr8}, {31'd0, z});
  endtask

  initial begin
    int n;
    int dones;

    // Reset, with START asserted to show RES dominates
    start8 = 1'b1;
    tick();
    tick();
    start8 = 1'b0;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_result", {24'd0, res8}, 32'd0);
    chk("rst_ac", {24'd0, ac8}, 32'd0);
    chk("rst_flags", {29'd0, acr8, avr8, zr8}, 32'd0);
    tick();

    run8(3'b000, 8'hF0, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "and");
    flags8("and", 8'h30, 1'b0, 1'b0, 1'b0);
    tick();
    chk("done_one_cycle", {31'd0, done8}, 32'd0);

    run8(3'b100, 8'h7F, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1);
    wait8(1, 2, "sum_bin");
    flags8("sum_bin", 8'h80, 1'b0, 1'b1, 1'b0);
    chk("sum_bin_ac", {24'd0, ac8}, 32'h80);

    // Back-to-back: accepted in the DONE cycle of the previous op
    run8(3'b001, 8'hF0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "eor");
    flags8("eor", 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("eor_ac_held", {24'd0, ac8}, 32'h80);

    run8(3'b010, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "or_zero");
    flags8("or_zero", 8'h00, 1'b0, 1'b0, 1'b1);

    run8(3'b011, 8'h81, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "srs");
    flags8("srs", 8'h40, 1'b1, 1'b0, 1'b0);

    run8(3'b101, 8'h50, 8'h30, 1'b1, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "dsub_bin");
    flags8("dsub_bin", 8'h20, 1'b1, 1'b0, 1'b0);

    run8(3'b101, 8'h80, 8'h01, 1'b1, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "dsub_ovf");
    flags8("dsub_ovf", 8'h7F, 1'b1, 1'b1, 1'b0);

    run8(3'b100, 8'h58, 8'h46, 1'b1, 1'b1, 3'd0, 1'b0);
    wait8(1, 3, "sum_dec");
    flags8("sum_dec", 8'h05, 1'b1, 1'b1, 1'b0);

    run8(3'b101, 8'h12, 8'h21, 1'b1, 1'b1, 3'd0, 1'b0);
    wait8(1, 3, "dsub_dec");
    flags8("dsub_dec", 8'h91, 1'b0, 1'b0, 1'b0);

    // SHRN with a stray START and operand change while busy
    run8(3'b110, 8'h85, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0);
    op8 = 3'b000; a8 = 8'h00; ci8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("shrn_busy_ignores_start", {31'd0, busy8}, 32'd1);
    wait8(2, 5, "shrn");
    flags8("shrn", 8'hF0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("shrn_no_queued_op", {31'd0, busy8}, 32'd0);

    run8(3'b110, 8'hA5, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "shrn0");
    flags8("shrn0", 8'hA5, 1'b0, 1'b0, 1'b0);

    run8(3'b111, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    wait8(1, 2, "reserved");
    flags8("reserved", 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset on the second SHF edge: accept=1, EXEC=2, SHF=3, SHF=4
    run8(3'b110, 8'hFF, 8'h00, 1'b0, 1'b0, 3'd5, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_result", {24'd0, res8}, 32'd0);
    chk("abort_ac", {24'd0, ac8}, 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done8) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);

    // WIDTH=16 decimal add with full carry ripple
    op16 = 3'b100; a16 = 16'h9999; b16 = 16'h0001; ci16 = 1'b0; dec16 = 1'b1;
    sh16 = 4'h0; acld16 = 1'b0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 1;
    while (!done16 && n < 40) begin
      tick();
      n++;
    end
    chk("w16_dec_latency", n, 3);
    chk("w16_dec_result", {16'd0, res16}, 32'h0000);
    chk("w16_dec_acr", {31'd0, acr16}, 32'd1);
    chk("w16_dec_zr", {31'd0, zr16}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
